sram_async_master: RTL and testbench
====================================

SRAM_ASYNC_MASTER -- requirements
Module: sram_async_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, meaning SRAM address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning SRAM data word width in bits.
REQ-003 SHALL have parameter RD_WAIT, default 2, meaning the number of clk cycles ce_n/oe_n are held low per read (>=1).
REQ-004 SHALL have parameter WR_WAIT, default 2, meaning the we_n low pulse width in clk cycles (>=1).
REQ-005 SHALL have port: clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port: req_valid  input  1  request present.
REQ-008 SHALL have port: req_ready  output  1  master idle, able to accept a request.
REQ-009 SHALL have port: req_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have port: req_addr  input  ADDR_WIDTH  target word address.
REQ-011 SHALL have port: req_wdata  input  DATA_WIDTH  write data.
REQ-012 SHALL have port: rsp_valid  output  1  one-cycle pulse marking rsp_rdata valid.
REQ-013 SHALL have port: rsp_rdata  output  DATA_WIDTH  read data.
REQ-014 SHALL have port: verify_err  output  1  sticky write-verify mismatch flag.
REQ-015 SHALL have port: sram_addr  output  ADDR_WIDTH  SRAM address pins.
REQ-016 SHALL have ports: sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.
REQ-017 SHALL have port: sram_data_inout  inout  DATA_WIDTH  bidirectional SRAM data bus.

Function
REQ-018 SHALL implement states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, and VFY (VFY only when configured in).
REQ-019 SHALL assert req_ready only in IDLE; a transfer is accepted on the edge where req_valid && req_ready, latching addr, we, and wdata.
REQ-020 SHALL ignore req_* outside the accept edge; latched values stay stable on sram_addr for the whole transfer.
REQ-021 SHALL go IDLE->RD on read accept; in RD drive ce_n=0, oe_n=0, we_n=1 for exactly RD_WAIT cycles, then sample sram_data_inout into rsp_rdata and return to IDLE.
REQ-022 SHALL pulse rsp_valid for exactly one cycle, in the IDLE cycle following RD; for a read accepted at edge T, rsp_valid is high during cycle T+RD_WAIT+1.
REQ-023 SHALL sequence a write as IDLE->WR_SETUP (1 cycle, ce_n=0, we_n=1) ->WR_PULSE (WR_WAIT cycles, we_n=0) ->WR_HOLD (1 cycle, we_n=1) ->IDLE, with oe_n=1 throughout.
REQ-024 SHALL drive sram_data_inout with latched wdata only in WR_SETUP, WR_PULSE, and WR_HOLD, and SHALL leave it high-Z in all other states.
REQ-025 SHALL make writes produce no rsp_valid; req_ready returns high WR_WAIT+3 cycles after accept.
REQ-026 SHALL allow back-to-back transfers: a request may be accepted in the same IDLE cycle in which rsp_valid is high.
REQ-027 SHALL use an RD_WAIT/WR_WAIT counter that is ceil(log2(max+1)) bits wide, loads on state entry, and never wraps.
REQ-028 SHALL hold sram_ce_n=1, oe_n=1, and we_n=1 in IDLE.

Reset
REQ-029 SHALL, on rst high at any edge (including mid-transfer), enter IDLE next cycle with ce_n=oe_n=we_n=1, bus high-Z, rsp_valid=0, rsp_rdata=0, verify_err=0, sram_addr=0, and req_ready=1, discarding the in-flight transfer.
REQ-030 SHALL take priority for rst over req_valid on the same edge.

Configuration
REQ-031 SHALL, when macro SRAM_WRITE_VERIFY_EN is defined, go WR_HOLD->VFY, perform a read identical to RD (RD_WAIT cycles), compare sampled data to latched wdata, set verify_err on mismatch (sticky until rst), and then return to IDLE without rsp_valid.
REQ-032 SHALL, when SRAM_WRITE_VERIFY_EN is undefined, go WR_HOLD->IDLE, omit VFY logic, and tie verify_err to 0.

Verification (with async SRAM model, defaults)
REQ-033 SHALL verify: preload mem[0xAAAAA]=0x1111, read 0xAAAAA accepted at T -> rsp_valid during T+3 only, rsp_rdata=0x1111, oe_n low exactly 2 cycles.
REQ-034 SHALL verify: write 0x5555 to 0x55555, then read 0x55555 -> mem[0x55555]=0x5555, we_n low exactly 2 cycles, bus driven exactly 4 cycles, rsp_rdata=0x5555.
REQ-035 SHALL verify: read 0xAAAAA, write accepted in the rsp_valid cycle, then read 0x55555 -> rsp 0x1111, then rsp of the new write data, with no idle gaps beyond the state sequence.
REQ-036 SHALL verify: rst asserted during WR_PULSE -> next cycle we_n=1, bus high-Z, req_ready=1, and no rsp_valid.
REQ-037 SHALL verify, with SRAM_WRITE_VERIFY_EN: backdoor-set mem[0x55555]=0x0000 during VFY of a 0x5555 write -> verify_err=1, held until rst; a clean write leaves verify_err=0.

Source files
------------

// File: rtl/sram_async_master.sv
// sram_async_master: single-port request/response master for an asynchronous
// SRAM. One transfer at a time; strobes, address and data-bus enable are all
// registered so the SRAM pins are glitch-free.
// Optional write-verify read-back is compiled in with `define SRAM_WRITE_VERIFY_EN.
module sram_async_master #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 16,
  parameter int RD_WAIT    = 2,
  parameter int WR_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  verify_err,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  inout  wire  [DATA_WIDTH-1:0] sram_data_inout
);

  localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  // Counter loads wait-1 and the state is left when it reaches zero, so it
  // never decrements past zero.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    VFY
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign sram_data_inout = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

`ifdef SRAM_WRITE_VERIFY_EN
  logic verify_flag;
  assign verify_err = verify_flag;
`else
  assign verify_err = 1'b0;
`endif

  // Write data is only captured on a write accept; it needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid && req_we) wdata_q <= req_wdata;
  end

  // Transfer sequencer with registered SRAM strobes and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drive_en  <= 1'b0;
`ifdef SRAM_WRITE_VERIFY_EN
      verify_flag <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            sram_addr <= req_addr;
            req_ready <= 1'b0;
            sram_ce_n <= 1'b0;
            if (req_we) begin
              state    <= WR_SETUP;
              drive_en <= 1'b1;
            end else begin
              state     <= RD;
              sram_oe_n <= 1'b0;
              cnt       <= RD_LOAD;
            end
          end
        end
        RD: begin
          if (cnt == '0) begin
            rsp_rdata <= sram_data_inout;
            rsp_valid <= 1'b1;
            state     <= IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          sram_we_n <= 1'b0;
          cnt       <= WR_LOAD;
        end
        WR_PULSE: begin
          if (cnt == '0) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HOLD: begin
          drive_en <= 1'b0;
`ifdef SRAM_WRITE_VERIFY_EN
          state     <= VFY;
          sram_oe_n <= 1'b0;
          cnt       <= RD_LOAD;
`else
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          req_ready <= 1'b1;
`endif
        end
`ifdef SRAM_WRITE_VERIFY_EN
        VFY: begin
          if (cnt == '0) begin
            if (sram_data_inout != wdata_q) verify_flag <= 1'b1;
            state     <= IDLE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          drive_en  <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_async_master.sv
// Testbench for sram_async_master: async SRAM model on the pins, a
// transaction-level reference model (cycles since accept), a per-cycle
// compare process and directed scenarios with literal expectations.
module tb_sram_async_master;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
`ifdef SRAM_WRITE_VERIFY_EN
  localparam bit VFY_ON = 1'b1;
`else
  localparam bit VFY_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready, rsp_valid, verify_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_addr;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  wire  [DW-1:0] sram_data_inout;

  sram_async_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .verify_err(verify_err), .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_data_inout(sram_data_inout)
  );

  always #5 clk = ~clk;

  // Async SRAM: low address byte selects the cell; write latches on we_n rise.
  logic [DW-1:0] mem [0:255];
  assign sram_data_inout = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : {DW{1'bz}};
  always @(posedge sram_we_n) if (sram_ce_n === 1'b0) mem[sram_addr[7:0]] = sram_data_inout;

  int n_checks = 0;
  int n_fail = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: k = clock edges since accept, -1 when idle.
  logic [DW-1:0] ref_mem [0:255];
  int edge_idx = 0, k = -1, len = 0, acc_edge = 0, lat_rdy = -1, lat_rsp = -1;
  bit kind_wr = 1'b0, exp_rvalid = 1'b0, exp_verr = 1'b0, corrupt_vfy = 1'b0, armed = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] m_wdata = 16'h5555, exp_rdata = '0;

  always @(posedge clk) begin
    edge_idx++;
    if (rst) begin
      k = -1; exp_rvalid = 1'b0; exp_rdata = '0; exp_verr = 1'b0; exp_addr = '0;
      corrupt_vfy = 1'b0; armed = 1'b1;
    end else begin
      exp_rvalid = 1'b0;
      if (k >= 0) begin
        k++;
        if (kind_wr && k == WR_WAIT + 2) ref_mem[exp_addr[7:0]] = m_wdata;
        if (k == len) begin
          if (!kind_wr) begin
            exp_rvalid = 1'b1;
            exp_rdata = ref_mem[exp_addr[7:0]];
          end else if (VFY_ON && corrupt_vfy) exp_verr = 1'b1;
          corrupt_vfy = 1'b0;
          k = -1;
        end
      end else if (req_valid) begin
        k = 0; kind_wr = req_we; exp_addr = req_addr; acc_edge = edge_idx;
        lat_rdy = -1; lat_rsp = -1;
        if (req_we) begin
          m_wdata = req_wdata;
          len = WR_WAIT + 2 + (VFY_ON ? RD_WAIT : 0);
        end else len = RD_WAIT;
      end
    end
  end

  // Per-cycle compare against the model, plus pin-activity counters.
  int cyc, oe_low = 0, we_low = 0, drv_cnt = 0, rsp_cnt = 0;
  bit exp_busy, exp_drv;
  always @(negedge clk) begin
    if (armed) begin
      cyc = edge_idx + 1;
      exp_busy = (k >= 0);
      exp_drv = exp_busy && kind_wr && (k <= WR_WAIT + 1);
      chk("req_ready", req_ready, !exp_busy);
      chk("ce_n", sram_ce_n, !exp_busy);
      chk("oe_n", sram_oe_n, !(exp_busy && (!kind_wr || k >= WR_WAIT + 2)));
      chk("we_n", sram_we_n, !(exp_busy && kind_wr && k >= 1 && k <= WR_WAIT));
      chk("sram_addr", sram_addr, exp_addr);
      chk("rsp_valid", rsp_valid, exp_rvalid);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("verify_err", verify_err, exp_verr);
      if (exp_drv) chk("bus_drive", sram_data_inout, m_wdata);
      else if (sram_oe_n) chk("bus_release", sram_data_inout === m_wdata, 0);
      if (!sram_oe_n) oe_low++;
      if (!sram_we_n) we_low++;
      if (sram_oe_n && sram_data_inout === m_wdata) drv_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (req_ready && lat_rdy < 0) lat_rdy = cyc - acc_edge;
      if (rsp_valid && lat_rsp < 0) lat_rsp = cyc - acc_edge;
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clr();
    oe_low = 0; we_low = 0; drv_cnt = 0; rsp_cnt = 0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    if (!req_ready) chk(name, req_ready, 1);
  endtask

  // Issue one request, wait for completion; returns ready/rsp latency and accept edge.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int lr, output int ls, output int ae);
    wait_ready("issue_timeout");
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_we = 1'b1; req_addr = 20'h0F0F0; req_wdata = 16'hBEEF;
    ae = acc_edge;
    wait_ready("done_timeout");
    lr = lat_rdy; ls = lat_rsp;
  endtask

  int lr, ls, ae, lr2, ls2, ae2;
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'h0100 + 16'(i);
      ref_mem[i] = 16'h0100 + 16'(i);
    end
    mem[8'hAA] = 16'h1111; ref_mem[8'hAA] = 16'h1111;

    // Reset state
    rst = 1'b1; req_valid = 1'b1;
    step(); step(); step();
    rst = 1'b0; req_valid = 1'b0;
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_rsp", {rsp_valid, rsp_rdata}, 17'h0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_verr", verify_err, 0);

    // Single read
    clr();
    issue(1'b0, 20'hAAAAA, 16'h0, lr, ls, ae);
    chk("rd_rsp_lat", ls, 3);
    chk("rd_ready_lat", lr, 3);
    chk("rd_data", rsp_rdata, 16'h1111);
    step();
    chk("rd_oe_low", oe_low, 2);
    chk("rd_rsp_cnt", rsp_cnt, 1);

    // Write then read back
    clr();
    issue(1'b1, 20'h55555, 16'h5555, lr, ls, ae);
    chk("wr_ready_lat", lr, 5);
    chk("wr_no_rsp", ls, -1);
    chk("wr_we_low", we_low, 2);
    chk("wr_drive", drv_cnt, 4);
    chk("wr_mem", mem[8'h55], 16'h5555);
    issue(1'b0, 20'h55555, 16'h0, lr, ls, ae);
    chk("wr_rdback", rsp_rdata, 16'h5555);

    // Back-to-back: write accepted in the rsp_valid cycle
    issue(1'b0, 20'hAAAAA, 16'h0, lr, ls, ae);
    chk("b2b_rsp_now", {rsp_valid, rsp_rdata}, {1'b1, 16'h1111});
    issue(1'b1, 20'h55555, 16'h7777, lr2, ls2, ae2);
    chk("b2b_wr_gap", ae2 - ae, 3);
    chk("b2b_wr_lat", lr2, 5);
    ae = ae2;
    issue(1'b0, 20'h55555, 16'h0, lr, ls, ae2);
    chk("b2b_rd_gap", ae2 - ae, 5);
    chk("b2b_rd_data", rsp_rdata, 16'h7777);
    chk("b2b_rd_lat", ls, 3);

    // Reset during WR_PULSE, with req_valid also high on the reset edge
    wait_ready("pre_rst_timeout");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h12345; req_wdata = 16'h5555;
    step();
    req_valid = 1'b0;
    step();
    chk("in_pulse", sram_we_n, 0);
    rst = 1'b1; req_valid = 1'b1;
    clr();
    step();
    rst = 1'b0; req_valid = 1'b0;
    chk("mid_rst_we", sram_we_n, 1);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_ce", sram_ce_n, 1);
    chk("mid_rst_bus", sram_data_inout === 16'h5555, 0);
    step();
    chk("mid_rst_idle", req_ready, 1);
    chk("mid_rst_no_rsp", rsp_cnt, 0);

`ifdef SRAM_WRITE_VERIFY_EN
    // Clean verified write, then a corrupted one
    issue(1'b1, 20'h55555, 16'h3333, lr, ls, ae);
    chk("vfy_clean", verify_err, 0);
    chk("vfy_lat", lr, 5 + RD_WAIT);
    corrupt_vfy = 1'b1;
    wait_ready("vfy_issue_timeout");
    req_valid = 1'b1; req_we = 1'b1; req_addr = 20'h55555; req_wdata = 16'h5555;
    step();
    req_valid = 1'b0;
    begin
      int n = 0;
      while (sram_oe_n && n < 50) begin step(); n++; end
      if (sram_oe_n) chk("vfy_oe_timeout", sram_oe_n, 0);
    end
    mem[8'h55] = 16'h0000; ref_mem[8'h55] = 16'h0000;
    wait_ready("vfy_done_timeout");
    chk("vfy_err_set", verify_err, 1);
    step(); step(); step();
    chk("vfy_err_sticky", verify_err, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("vfy_err_rst", verify_err, 0);
`endif

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x1, expected 0x0");
    $fatal(1, "timeout");
  end
endmodule
